// File: rtl/ex_md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package ex_md_unit_pkg;

    // md_op encodings as presented by the ID/EX register.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer state: IDLE has counter 0, RUN has counter > 0.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Default busy lengths (legal range 1..15, counter is 4 bits).
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // MIPS SPECIAL-opcode function codes that touch HI/LO.
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;

    // md-class instructions: the hazard unit stalls these in ID while
    // the unit reports md_hold.
    function automatic logic is_md_class(input logic [5:0] opcode,
                                         input logic [5:0] funct);
        logic hit;
        hit = 1'b0;
        if (opcode == OPC_SPECIAL) begin
            case (funct)
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: hit = 1'b1;
                default:                            hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

endpackage

// File: rtl/ex_md_unit_calc.sv
// Combinational 64-bit product and quotient/remainder for mult/multu/div/divu.
// Latency: 0 cycles (pure combinational; the top spreads it over the busy window).
// Backpressure: none; outputs follow inputs.
// Ports: md_op/src_a/src_b in; res_hi/res_lo (HI/LO candidates) and div_by_zero out.
module md_result_calc
    import ex_md_unit_pkg::*;
(
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    md_op_e      op;
    logic        is_signed;
    logic        is_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign op        = md_op_e'(md_op);
    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign is_div    = (op == MD_DIV) || (op == MD_DIVU);

    // Low 64 bits of the extended product are exact for both signednesses.
    assign a_ext   = {{32{is_signed & src_a[31]}}, src_a};
    assign b_ext   = {{32{is_signed & src_b[31]}}, src_b};
    assign product = a_ext * b_ext;

    // Signed divide done on magnitudes so truncation toward zero and the
    // remainder-follows-dividend rule are explicit. 0x80000000 has magnitude
    // 0x80000000 as an unsigned value, so 0x80000000 / -1 yields 0x80000000
    // with remainder 0 without a special case.
    assign a_neg = is_signed & src_a[31];
    assign b_neg = is_signed & src_b[31];
    assign mag_a = a_neg ? (32'd0 - src_a) : src_a;
    assign mag_b = b_neg ? (32'd0 - src_b) : src_b;

    // Divisor forced to 1 on zero so the datapath never sees x; the result is
    // discarded through div_by_zero anyway.
    assign div_by_zero = is_div && (src_b == 32'd0);
    assign div_b       = (src_b == 32'd0) ? 32'd1 : mag_b;
    assign quo_mag     = mag_a / div_b;
    assign rem_mag     = mag_a % div_b;
    assign quotient    = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign remainder   = a_neg ? (32'd0 - rem_mag) : rem_mag;

    assign res_hi = is_div ? remainder : product[63:32];
    assign res_lo = is_div ? quotient  : product[31:0];

endmodule

// File: rtl/ex_md_unit.sv
// EX-stage multiply/divide unit owning architectural HI/LO, plus mthi/mtlo.
// Latency: start at T -> busy T+1..T+N -> new HI/LO visible at T+N+1 (N = MULT_CYCLES/DIV_CYCLES).
// Backpressure: none accepted; md_hold (busy|start) tells the hazard unit to stall md-class ops in ID.
// Ports: clk/reset_n; start, md_op, src_a, src_b (operation); hi_we, lo_we, wdata (mthi/mtlo);
//        busy, md_hold, hi, lo out.
module ex_md_unit
    import ex_md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        md_hold,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    md_state_e   state_q,      state_d;
    logic [3:0]  counter_q,    counter_d;
    logic [31:0] pending_hi_q, pending_hi_d;
    logic [31:0] pending_lo_q, pending_lo_d;
    logic        pending_wr_q, pending_wr_d;
    logic [31:0] hi_q,         hi_d;
    logic [31:0] lo_q,         lo_d;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_dz;

    md_result_calc u_calc (
        .md_op       (md_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .res_hi      (calc_hi),
        .res_lo      (calc_lo),
        .div_by_zero (calc_dz)
    );

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        pending_wr_d = pending_wr_q;
        hi_d         = hi_q;
        lo_d         = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Result is captured up front; the busy window only
                    // models the architectural latency. Same-cycle mthi/mtlo
                    // are dropped because start takes priority.
                    pending_hi_d = calc_hi;
                    pending_lo_d = calc_lo;
                    pending_wr_d = ~calc_dz;
                    // md_op[1] distinguishes div/divu from mult/multu.
                    counter_d    = md_op[1] ? DIV_CNT : MULT_CNT;
                    state_d      = ST_RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_RUN: begin
                // start/hi_we/lo_we are ignored here; the hazard unit keeps
                // them away while md_hold is high.
                counter_d = counter_q - 4'd1;
                if (counter_q == 4'd1) begin
                    state_d = ST_IDLE;
                    // Divide by zero leaves HI/LO untouched.
                    if (pending_wr_q) begin
                        hi_d = pending_hi_q;
                        lo_d = pending_lo_q;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            counter_q    <= 4'd0;
            pending_hi_q <= 32'd0;
            pending_lo_q <= 32'd0;
            pending_wr_q <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            pending_wr_q <= pending_wr_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign md_hold = busy | start;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_ex_md_unit.sv
module tb_ex_md_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        md_hold;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    // Bench-side architectural HI/LO model.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    ex_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .src_a   (src_a),
        .src_b   (src_b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .md_hold (md_hold),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags issue of start/mthi/mtlo while busy, which the hazard unit must prevent.
    always @(negedge clk) begin
        if (reset_n && busy && (start || hi_we || lo_we)) begin
            failures++;
            $error("FAIL illegal_issue_while_busy start=%0b hi_we=%0b lo_we=%0b", start, hi_we, lo_we);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one md op at cycle T, check hold/busy over T..T+n, then result at T+n+1.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic with_write,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        hi_we = with_write;
        lo_we = with_write;
        wdata = 32'hDEADBEEF;
        #1;
        check({tag, "_hold_T"}, {31'd0, md_hold}, 32'd1);
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        #1;
        for (int i = 1; i <= n; i++) begin
            check($sformatf("%s_busy_T%0d", tag, i), {31'd0, busy}, 32'd1);
            check($sformatf("%s_hold_T%0d", tag, i), {31'd0, md_hold}, 32'd1);
            if (i == 1 || i == n) begin
                check($sformatf("%s_hi_held_T%0d", tag, i), hi, m_hi);
                check($sformatf("%s_lo_held_T%0d", tag, i), lo, m_lo);
            end
            tick();
        end
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold_done"}, {31'd0, md_hold}, 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        int waited;
        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = 2'b00;
        src_a   = 32'd0;
        src_b   = 32'd0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = 32'd0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        #7;
        reset_n = 1'b1;
        tick();

        // Reset state.
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hold", {31'd0, md_hold}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // Arithmetic.
        run_op("mult_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 32'h00000000, 32'h00000001);
        run_op("multu_m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_7_2", 2'b11, 32'h00000007, 32'h00000002, 10, 1'b0, 32'h00000001, 32'h00000003);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'h00000000, 32'h80000000);

        // mthi / mtlo while idle: one-cycle effect, no busy.
        hi_we = 1'b1;
        wdata = 32'h12345678;
        #1;
        check("mthi_hold", {31'd0, md_hold}, 32'd0);
        tick();
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo_kept", lo, 32'h80000000);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        lo_we = 1'b1;
        wdata = 32'h0000000A;
        tick();
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h0000000A);
        check("mtlo_hi_kept", hi, 32'h12345678);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'h12345678;
        m_lo = 32'h0000000A;

        // Divide by zero: normal busy window, HI/LO unchanged.
        run_op("div_by_0", 2'b10, 32'h00000005, 32'h00000000, 10, 1'b0, 32'h12345678, 32'h0000000A);

        // Asynchronous reset in the 3rd busy cycle of a div.
        start = 1'b1;
        md_op = 2'b10;
        src_a = 32'd100;
        src_b = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("arst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        #3;
        reset_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (12) tick();
        check("arst_no_commit_busy", {31'd0, busy}, 32'd0);
        check("arst_no_commit_hi", hi, 32'd0);
        check("arst_no_commit_lo", lo, 32'd0);

        // mult followed by mthi stalled by the hazard-unit model on md_hold.
        start = 1'b1;
        md_op = 2'b00;
        src_a = 32'd3;
        src_b = 32'hFFFFFFFE;
        tick();
        start = 1'b0;
        #1;
        waited = 0;
        while (md_hold === 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("haz_stall_cycles", 32'(waited), 32'd5);
        check("haz_prod_hi", hi, 32'hFFFFFFFF);
        check("haz_prod_lo", lo, 32'hFFFFFFFA);
        hi_we = 1'b1;
        wdata = 32'hCAFEF00D;
        tick();
        hi_we = 1'b0;
        check("haz_mthi_hi", hi, 32'hCAFEF00D);
        check("haz_mthi_lo_kept", lo, 32'hFFFFFFFA);
        check("haz_mthi_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'hCAFEF00D;
        m_lo = 32'hFFFFFFFA;

        // start and mthi/mtlo in the same idle cycle: start wins, writes dropped.
        run_op("start_wins", 2'b01, 32'd2, 32'd3, 5, 1'b1, 32'h00000000, 32'h00000006);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
